// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags.
//   master: drives clr, w_en, Data_in, rd_en and observes data, flags, count and peak.
//   slave : the FIFO side, with the directions reversed.
interface sync_fifo_flags_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned NUM_BITS  = 4
);
  logic                 clr;
  logic                 w_en;
  logic [DATA_BITS-1:0] Data_in;
  logic                 rd_en;
  logic [DATA_BITS-1:0] Data_out;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [NUM_BITS:0]    count;
  logic [NUM_BITS:0]    peak;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output clr, w_en, Data_in, rd_en,
    input  Data_out, full, empty, almost_full, almost_empty, count, peak, overflow, underflow
  );

  modport slave (
    input  clr, w_en, Data_in, rd_en,
    output Data_out, full, empty, almost_full, almost_empty, count, peak, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, peak tracking, almost-full/almost-empty flags,
// sticky overflow/underflow, synchronous clear and a registered or FWFT read port.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - sync_fifo_flags_if.slave: clr, w_en, Data_in, rd_en in;
//          Data_out, full, empty, almost_full, almost_empty, count, peak, overflow, underflow out
module sync_fifo_flags #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_BITS   = 4,
  parameter int unsigned AFULL_LVL  = 12,
  parameter int unsigned AEMPTY_LVL = 4,
  parameter int unsigned FWFT       = 0
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_flags_if.slave bus
);
  localparam int unsigned CW = NUM_BITS + 1;

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [CW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q,  count_d;
  logic [CW-1:0]        peak_q,   peak_d;
  logic                 full_q,   full_d;
  logic                 empty_q,  empty_d;
  logic                 afull_q,  afull_d;
  logic                 aempty_q, aempty_d;
  logic                 ovf_q,    ovf_d;
  logic                 udf_q,    udf_d;
  logic [DATA_BITS-1:0] dout_q,   dout_d;
  logic                 wr_ok, rd_ok;
  logic [DATA_BITS-1:0] head;

  assign head = mem[rd_ptr_q[NUM_BITS-1:0]];

  // Next-state: acceptance from pre-edge flags, clear has priority, flags decoded from next count.
  always_comb begin
    wr_ok    = bus.w_en  && !full_q;
    rd_ok    = bus.rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    dout_d   = dout_q;
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + CW'(1);
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + CW'(1);
        if (FWFT == 0) dout_d = head;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (bus.w_en  && full_q)  ovf_d = 1'b1;
      if (bus.rd_en && empty_q) udf_d = 1'b1;
    end
    peak_d   = bus.clr ? '0 : ((count_d > peak_q) ? count_d : peak_q);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AFULL_LVL));
    aempty_d = (count_d <= CW'(AEMPTY_LVL));
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peak_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dout_q   <= dout_d;
    end
  end

  // Storage array; contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !bus.clr) mem[wr_ptr_q[NUM_BITS-1:0]] <= bus.Data_in;
  end

  // FWFT presents the head word straight from the array while non-empty.
  assign bus.Data_out     = (FWFT != 0) ? (empty_q ? '0 : head) : dout_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.peak         = peak_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule
